// File: rtl/apb_uart_tx_completer.sv
// rtl/apb_uart_tx_completer.sv - APB4 completer feeding a byte FIFO into an 8N1 UART transmitter.
// Wait states are inserted on TXDATA writes while the FIFO is full and the transmitter is enabled.
module apb_uart_tx_completer #(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        tx,
    output logic        irq_txe
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
    localparam logic [3:0]    DEPTH     = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    count;
    logic          tx_en, irq_en;

    state_t        state, state_next;
    logic [BW-1:0] baud, baud_next;
    logic [2:0]    bit_cnt, bit_next;
    logic [7:0]    shift, shift_next;
    logic          pop;

    logic [1:0] reg_sel;
    logic       access, full, empty, busy;
    logic       wr_data_sel, stall, push, ctrl_wr, flush;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign reg_sel     = PADDR[3:2];
    assign access      = PSEL & PENABLE;
    assign full        = (count == DEPTH);
    assign empty       = (count == 4'd0);
    assign busy        = (state != IDLE);
    assign wr_data_sel = access & PWRITE & (reg_sel == 2'd0) & PSTRB[0];

    // Full FIFO count is registered, so a stalled write sees room only the cycle after a pop.
    assign stall   = wr_data_sel & full & tx_en;
    assign PREADY  = access & ~stall;
    assign ctrl_wr = PREADY & PWRITE & (reg_sel == 2'd2) & PSTRB[0];
    assign flush   = ctrl_wr & PWDATA[1];
    assign push    = PREADY & wr_data_sel & ~full & ~flush;
    assign PSLVERR = PREADY & ((reg_sel == 2'd3) |
                               ((reg_sel == 2'd1) & PWRITE) |
                               (wr_data_sel & full & ~tx_en));

    always_comb begin
        PRDATA = 32'h0;
        if (access && !PWRITE) begin
            case (reg_sel)
                2'd1:    PRDATA = {24'h0, count, 1'b0, busy, empty, full};
                2'd2:    PRDATA = {29'h0, irq_en, 1'b0, tx_en};
                default: PRDATA = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
            tx_en  <= 1'b1;
            irq_en <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                tx_en  <= PWDATA[0];
                irq_en <= PWDATA[2];
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
                count  <= 4'd0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                count <= count + {3'b0, push} - {3'b0, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= PWDATA[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= 3'd0;
            shift   <= 8'h0;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_cnt <= bit_next;
            shift   <= shift_next;
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud;
        bit_next   = bit_cnt;
        shift_next = shift;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (tx_en && !empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    baud_next  = BAUD_LAST;
                    state_next = START;
                end
            end
            START: begin
                if (baud == '0) begin
                    baud_next  = BAUD_LAST;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud - 1'b1;
                end
            end
            DATA: begin
                if (baud == '0) begin
                    baud_next  = BAUD_LAST;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) state_next = STOP;
                    else                 bit_next   = bit_cnt + 3'd1;
                end else begin
                    baud_next = baud - 1'b1;
                end
            end
            STOP: begin
                if (baud == '0) begin
                    // Back-to-back frames: the next start bit follows the stop bit directly.
                    if (tx_en && !empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        baud_next  = BAUD_LAST;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx      = (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
    assign irq_txe = irq_en & empty & (state == IDLE);

    logic unused;
    assign unused = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:8], PSTRB[3:1]};

endmodule

// File: tb/tb_apb_uart_tx_completer.sv
// tb/tb_apb_uart_tx_completer.sv - scoreboard bench for apb_uart_tx_completer.
// APB responses and decoded UART frames are checked against queues filled by the stimulus.
module tb_apb_uart_tx_completer;

    localparam int BD = 4;
    localparam int FD = 8;

    logic        clk;
    logic        rst;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        tx, irq_txe;

    apb_uart_tx_completer #(.BAUD_DIV(BD), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx(tx), .irq_txe(irq_txe)
    );

    typedef struct {
        logic        chk_rd;
        logic [31:0] rdata;
        logic        err;
        int          id;
    } sb_t;

    sb_t        sb_q[$];
    logic [7:0] exp_tx[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         xfer_id = 0;
    int         last_start = -1;
    logic       gap_chk = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 50000) begin
            $display("FAIL watchdog cycles=%0d limit=50000", cyc);
            $fatal(1, "watchdog");
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endfunction

    // APB monitor: every completed transfer is matched against the next expected response.
    always @(negedge clk) begin
        sb_t it;
        if (PSEL && PENABLE && PREADY) begin
            if (sb_q.size() == 0) begin
                fail_now("apb_unexpected_xfer");
            end else begin
                it = sb_q.pop_front();
                check($sformatf("xfer%0d_pslverr", it.id), {31'h0, PSLVERR}, {31'h0, it.err});
                if (it.chk_rd)
                    check($sformatf("xfer%0d_prdata", it.id), PRDATA, it.rdata);
            end
        end
    end

    // UART monitor: decodes 8N1 frames by sampling mid-bit, offsets counted from the first low cycle.
    int         m_phase = 0;
    int         m_cnt = 0;
    logic [7:0] m_sh;
    always @(negedge clk) begin
        if (!rst) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (tx == 1'b0) begin
                m_phase = 1;
                m_cnt = 0;
                if (gap_chk && last_start >= 0)
                    check("frame_period", cyc - last_start, 10 * BD);
                last_start = cyc;
            end
        end else begin
            m_cnt++;
            if (m_cnt == BD / 2)
                check("start_bit", {31'h0, tx}, 32'h0);
            for (int i = 0; i < 8; i++)
                if (m_cnt == BD * (i + 1) + BD / 2) m_sh[i] = tx;
            if (m_cnt == BD * 9 + BD / 2) begin
                check("stop_bit", {31'h0, tx}, 32'h1);
                if (exp_tx.size() == 0) fail_now("tx_unexpected_frame");
                else check("tx_byte", {24'h0, m_sh}, {24'h0, exp_tx.pop_front()});
                m_phase = 0;
            end
        end
    end

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [31:0] exp_rd, input logic exp_err,
                       output int waits);
        sb_t it;
        it.chk_rd = !wr;
        it.rdata  = exp_rd;
        it.err    = exp_err;
        it.id     = xfer_id;
        xfer_id++;
        sb_q.push_back(it);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = addr; PWDATA = data; PSTRB = strb;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!PREADY && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!PREADY) fail_now("apb_pready_timeout");
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'h0; PWDATA = 32'h0; PSTRB = 4'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic e, output int w);
        apb(1'b1, a, d, s, 32'h0, e, w);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic e);
        int w;
        apb(1'b0, a, 32'h0, 4'h0, exp, e, w);
    endtask

    task automatic wait_tx_drain();
        int n = 0;
        while (exp_tx.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (exp_tx.size() != 0) fail_now("tx_drain_timeout");
    endtask

    initial begin
        int w;
        rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'h0; PWDATA = 32'h0; PSTRB = 4'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_irq", {31'h0, irq_txe}, 32'h0);
        check("idle_prdata", PRDATA, 32'h0);
        check("idle_pready", {31'h0, PREADY}, 32'h0);
        check("idle_pslverr", {31'h0, PSLVERR}, 32'h0);
        rd(32'h4, 32'h2, 1'b0);
        rd(32'h8, 32'h1, 1'b0);

        // Single 0xA5 frame: start bit one edge after the push
        exp_tx.push_back(8'hA5);
        wr(32'h0, 32'hA5, 4'h1, 1'b0, w);
        check("a5_waits", w, 0);
        @(negedge clk);
        check("a5_tx_before_pop", {31'h0, tx}, 32'h1);
        @(negedge clk);
        check("a5_tx_start", {31'h0, tx}, 32'h0);
        repeat (40) @(negedge clk);
        check("a5_drained", exp_tx.size(), 0);
        rd(32'h4, 32'h2, 1'b0);

        // Fill with transmitter disabled, overflow drops the byte
        wr(32'h8, 32'h0, 4'h1, 1'b0, w);
        for (int i = 0; i < FD; i++) begin
            wr(32'h0, 32'h50 + i, 4'h1, 1'b0, w);
            check("fill_waits", w, 0);
        end
        rd(32'h4, 32'h81, 1'b0);
        wr(32'h0, 32'hEE, 4'h1, 1'b1, w);
        check("overflow_waits", w, 0);
        rd(32'h4, 32'h81, 1'b0);
        wr(32'h8, 32'h2, 4'h1, 1'b0, w);
        rd(32'h4, 32'h02, 1'b0);
        wr(32'h8, 32'h4, 4'h1, 1'b0, w);
        check("irq_set", {31'h0, irq_txe}, 32'h1);
        rd(32'h8, 32'h4, 1'b0);
        wr(32'h8, 32'h1, 4'h1, 1'b0, w);
        check("irq_clr", {31'h0, irq_txe}, 32'h0);
        wr(32'h8, 32'h0, 4'h0, 1'b0, w);
        rd(32'h8, 32'h1, 1'b0);

        // Ten back-to-back bytes: the tenth stalls until the first frame ends
        gap_chk = 1'b1;
        last_start = -1;
        for (int i = 0; i < 10; i++) begin
            exp_tx.push_back(8'h30 + 8'(i));
            wr(32'h0, 32'h30 + i, 4'h1, 1'b0, w);
            if (i < 9) check("b2b_waits", w, 0);
            else       check("b2b_stall_waits", w, 24);
        end
        wait_tx_drain();
        repeat (4) @(negedge clk);
        gap_chk = 1'b0;
        rd(32'h4, 32'h2, 1'b0);

        // Error paths
        rd(32'hC, 32'h0, 1'b1);
        wr(32'h4, 32'hFF, 4'hF, 1'b1, w);
        rd(32'h4, 32'h2, 1'b0);
        wr(32'h0, 32'h77, 4'b0010, 1'b0, w);
        rd(32'h4, 32'h2, 1'b0);
        rd(32'h0, 32'h0, 1'b0);

        // Flush with three queued behind a frame in flight
        exp_tx.push_back(8'hC3);
        wr(32'h0, 32'hC3, 4'h1, 1'b0, w);
        wr(32'h0, 32'h01, 4'h1, 1'b0, w);
        wr(32'h0, 32'h02, 4'h1, 1'b0, w);
        wr(32'h0, 32'h03, 4'h1, 1'b0, w);
        wr(32'h8, 32'h3, 4'h1, 1'b0, w);
        rd(32'h4, 32'h6, 1'b0);
        wait_tx_drain();
        repeat (60) @(negedge clk);
        rd(32'h4, 32'h2, 1'b0);

        // Reset during the data bits aborts the frame
        wr(32'h0, 32'h3C, 4'h1, 1'b0, w);
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_tx", {31'h0, tx}, 32'h1);
        rd(32'h4, 32'h2, 1'b0);
        rd(32'h8, 32'h1, 1'b0);
        repeat (60) @(negedge clk);

        check("sb_empty", sb_q.size(), 0);
        check("tx_q_empty", exp_tx.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
